// File: rtl/join4_pkg.sv
// Shared types and constants for the four-channel four-phase join.
// Synchronizer depth is 3 when JOIN4_SYNC_3STAGE_EN is defined, otherwise 2.
package join4_pkg;

  localparam int NCH = 4;

`ifdef JOIN4_SYNC_3STAGE_EN
  localparam int SYNC_STAGES = 3;
`else
  localparam int SYNC_STAGES = 2;
`endif

  localparam logic [NCH-1:0] REQ_ALL  = {NCH{1'b1}};
  localparam logic [NCH-1:0] REQ_NONE = {NCH{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    ACK  = 2'd2
  } state_e;

  function automatic logic any_fall(input logic [NCH-1:0] prev, input logic [NCH-1:0] cur);
    return |(prev & ~cur);
  endfunction

  function automatic logic any_rise(input logic [NCH-1:0] prev, input logic [NCH-1:0] cur);
    return |(~prev & cur);
  endfunction

endpackage

// File: rtl/join4_sync_req_sync.sv
// Single-bit flop-chain synchronizer with asynchronous active-high clear.
module req_sync #(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] stage_r;

  // Shift the asynchronous input through the chain; clear drops every stage at once.
  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      stage_r <= {DEPTH{1'b0}};
    end else begin
      stage_r <= {stage_r[DEPTH-2:0], d_i};
    end
  end

  assign q_o = stage_r[DEPTH-1];

endmodule

// File: rtl/join4_sync.sv
// Joins four asynchronous four-phase request channels into one valid/ready word.
// Build option: JOIN4_SYNC_3STAGE_EN selects a 3-stage request synchronizer.
module join4_sync
  import join4_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NCH-1:0]    req_i,
  input  logic [NCH*DW-1:0] data_i,
  output logic [NCH-1:0]    ack_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [NCH*DW-1:0] out_data_o,
  output logic              err_o
);

  logic [NCH-1:0]    req_s;
  logic [NCH-1:0]    req_q_r;
  state_e            state_r;
  logic [NCH-1:0]    ack_r;
  logic              out_valid_r;
  logic [NCH*DW-1:0] out_data_r;
  logic              err_r;
  logic              err_det_s;

  for (genvar ch = 0; ch < NCH; ch++) begin : g_sync
    req_sync #(.DEPTH(SYNC_STAGES)) u_sync (
      .clk_i (clk_i),
      .clr_i (rst_i),
      .d_i   (req_i[ch]),
      .q_o   (req_s[ch])
    );
  end

  // Flag requests withdrawn before acknowledge, or re-raised before release completes.
  always_comb begin
    err_det_s = 1'b0;
    case (state_r)
      IDLE, HOLD: err_det_s = any_fall(req_q_r, req_s);
      ACK:        err_det_s = any_rise(req_q_r, req_s);
      default:    err_det_s = 1'b0;
    endcase
  end

  // Handshake sequencing; errors are only recorded and never alter the flow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= IDLE;
      req_q_r     <= REQ_NONE;
      ack_r       <= REQ_NONE;
      out_valid_r <= 1'b0;
      out_data_r  <= {(NCH*DW){1'b0}};
      err_r       <= 1'b0;
    end else begin
      req_q_r <= req_s;
      err_r   <= err_r | err_det_s;
      case (state_r)
        IDLE: begin
          if (req_s == REQ_ALL) begin
            out_data_r  <= data_i;
            out_valid_r <= 1'b1;
            state_r     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready_i) begin
            out_valid_r <= 1'b0;
            ack_r       <= REQ_ALL;
            state_r     <= ACK;
          end
        end
        ACK: begin
          if (req_s == REQ_NONE) begin
            ack_r   <= REQ_NONE;
            state_r <= IDLE;
          end
        end
        default: begin
          ack_r       <= REQ_NONE;
          out_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign ack_o       = ack_r;
  assign out_valid_o = out_valid_r;
  assign out_data_o  = out_data_r;
  assign err_o       = err_r;

endmodule

// File: tb/tb_join4_sync.sv
// Randomized and directed bench for join4_sync (DW=8) against a transaction-level model.
// Honors JOIN4_SYNC_3STAGE_EN to match the synchronizer depth of the build under test.
module tb_join4_sync;

`ifdef JOIN4_SYNC_3STAGE_EN
  localparam int N = 3;
`else
  localparam int N = 2;
`endif
  localparam int LAT = N + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_i = 4'd0;
  logic [31:0] data_i = 32'd0;
  logic        out_ready_i = 1'b0;
  logic [3:0]  ack_o;
  logic        out_valid_o;
  logic [31:0] out_data_o;
  logic        err_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  join4_sync #(.DW(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req_i),
    .data_i      (data_i),
    .ack_o       (ack_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: req history models the synchronizer delay; phase 0 wait, 1 holding, 2 acking.
  logic [3:0]  hist [N];
  logic [3:0]  m_prev, rs;
  int          phase;
  logic [31:0] m_data;
  logic        m_err;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) hist[i] = 4'd0;
      m_prev = 4'd0; phase = 0; m_data = 32'd0; m_err = 1'b0;
    end else begin
      rs = hist[N-1];
      if ((phase != 2) && ((m_prev & ~rs) != 4'd0)) m_err = 1'b1;
      if ((phase == 2) && ((rs & ~m_prev) != 4'd0)) m_err = 1'b1;
      case (phase)
        0: if (rs == 4'hF) begin m_data = data_i; phase = 1; end
        1: if (out_ready_i) phase = 2;
        2: if (rs == 4'h0) phase = 0;
        default: phase = 0;
      endcase
      m_prev = rs;
      for (int i = N-1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = req_i;
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", {31'd0, out_valid_o}, {31'd0, phase == 1});
      check("ack", {28'd0, ack_o}, (phase == 2) ? 32'hF : 32'h0);
      check("data", out_data_o, m_data);
      check("err", {31'd0, err_o}, {31'd0, m_err});
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  int r;
  logic [31:0] held;

  initial begin
    // Reset state, observed before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst_valid", {31'd0, out_valid_o}, 32'd0);
    check("rst_ack", {28'd0, ack_o}, 32'd0);
    check("rst_data", out_data_o, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    chk_en = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);

    // Basic transaction.
    req_i = 4'hF; data_i = 32'hA1B2C3D4; out_ready_i = 1'b1;
    for (int i = 1; i < LAT; i++) begin
      tick();
      check("basic_valid_early", {31'd0, out_valid_o}, 32'd0);
    end
    tick();
    check("basic_valid", {31'd0, out_valid_o}, 32'd1);
    check("basic_data", out_data_o, 32'hA1B2C3D4);
    tick();
    check("basic_ack", {28'd0, ack_o}, 32'hF);
    req_i = 4'h0;
    for (int i = 1; i < LAT; i++) begin
      tick();
      check("basic_ack_hold", {28'd0, ack_o}, 32'hF);
    end
    tick();
    check("basic_ack_drop", {28'd0, ack_o}, 32'h0);
    tick(2);

    // Staggered arrival.
    data_i = 32'h11223344;
    for (int b = 0; b < 4; b++) begin
      req_i[b] = 1'b1;
      tick(b == 3 ? 1 : 10);
    end
    for (int i = 2; i < LAT; i++) tick();
    check("stagger_valid_early", {31'd0, out_valid_o}, 32'd0);
    tick();
    check("stagger_valid", {31'd0, out_valid_o}, 32'd1);
    check("stagger_data", out_data_o, 32'h11223344);
    tick();
    req_i = 4'h0;
    tick(LAT + 2);

    // Backpressure.
    out_ready_i = 1'b0; req_i = 4'hF; data_i = 32'h5A6B7C8D;
    tick(LAT);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_valid", {31'd0, out_valid_o}, 32'd1);
      check("bp_data", out_data_o, 32'h5A6B7C8D);
      check("bp_ack", {28'd0, ack_o}, 32'h0);
    end
    out_ready_i = 1'b1;
    tick();
    check("bp_ack_rise", {28'd0, ack_o}, 32'hF);
    req_i = 4'h0;
    tick(LAT + 2);

    // Protocol error: withdraw one request before acknowledge.
    req_i = 4'h7;
    tick(LAT + 1);
    req_i = 4'h6;
    tick(LAT + 1);
    check("perr_err", {31'd0, err_o}, 32'd1);
    check("perr_idle", {31'd0, out_valid_o}, 32'd0);
    req_i = 4'h0;
    tick(5);
    check("perr_sticky", {31'd0, err_o}, 32'd1);
    // Normal sequencing continues with the error flag set.
    req_i = 4'hF; data_i = 32'hCAFEF00D;
    tick(LAT + 2);
    req_i = 4'h0;
    tick(LAT + 2);
    check("perr_sticky2", {31'd0, err_o}, 32'd1);

    // Reset while acknowledging abandons the transaction immediately.
    do_reset();
    req_i = 4'hF; data_i = 32'h0BADBEEF;
    tick(LAT + 1);
    check("mid_ack", {28'd0, ack_o}, 32'hF);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ack", {28'd0, ack_o}, 32'd0);
    check("mid_rst_valid", {31'd0, out_valid_o}, 32'd0);
    check("mid_rst_data", out_data_o, 32'd0);
    tick(2);
    rst = 1'b0;
    out_ready_i = 1'b0;
    tick(LAT);
    check("rearrive_valid", {31'd0, out_valid_o}, 32'd1);
    check("rearrive_data", out_data_o, 32'h0BADBEEF);
    out_ready_i = 1'b1;
    tick();
    req_i = 4'h0;
    tick(LAT + 2);

    // Randomized four-phase agents with occasional violations and resets.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int ch = 0; ch < 4; ch++) begin
        r = int'($urandom_range(0, 3));
        if (!req_i[ch] && !ack_o[ch] && r == 0) begin
          data_i[ch*8 +: 8] = 8'($urandom);
          req_i[ch] = 1'b1;
        end else if (req_i[ch] && ack_o[ch] && r == 0) begin
          req_i[ch] = 1'b0;
        end
      end
      out_ready_i = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 99) == 0) req_i[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
      tick();
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
